alu_issue_ctrl: RTL and testbench

Front-end sequencer that drives the team's 8-bit registered ALU. It accepts one operation at a time over a valid/ready request port and reads operands from a small internal register file. It raises exactly one ALU control strobe for one cycle, then captures the ALU's registered result and flags. It writes the result back, holds an architectural flag register, and returns a one-cycle response pulse.

---
 rtl/alu_issue_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the 8-bit registered ALU: it accepts one request, strobes the ALU once,
// captures the result and flags, writes the result back and pulses a response.
module alu_issue_ctrl #(
    parameter int          REG_AW  = 2,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [REG_AW-1:0] req_rd,
    input  logic [REG_AW-1:0] req_rs,
    input  logic [7:0]        req_imm,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              flag_cf,
    output logic              flag_af,
    output logic              flag_zf,
    output logic              flag_sf,
    output logic              flag_of,
    output logic              alu_add,
    output logic              alu_sub,
    output logic              alu_inc,
    output logic              alu_dec,
    output logic [7:0]        alu_x,
    output logic [7:0]        alu_y,
    input  logic [7:0]        alu_res,
    input  logic              alu_cf,
    input  logic              alu_af,
    input  logic              alu_zf,
    input  logic              alu_sf,
    input  logic              alu_of,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam int NREG = 2 ** REG_AW;

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_INC = 3'd3;
    localparam logic [2:0] OP_DEC = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_MOV = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state_q;
    logic [7:0]        regs_q [NREG];
    logic [2:0]        op_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic [7:0]        rsp_data_q;
    logic [4:0]        flags_q;     // {cf, af, zf, sf, of}
    logic [3:0]        strobe_q;    // {add, sub, inc, dec}

    logic [3:0]        strobe_d;
    logic              issue_alu_d;
    logic [7:0]        direct_data_d;

    // Decode the incoming opcode into an ALU strobe and the direct (non-ALU) result value.
    always_comb begin
        strobe_d      = 4'b0000;
        issue_alu_d   = 1'b0;
        direct_data_d = regs_q[req_rd];
        case (req_op)
            OP_ADD: begin
                strobe_d    = 4'b1000;
                issue_alu_d = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                strobe_d    = 4'b0100;
                issue_alu_d = 1'b1;
            end
            OP_INC: begin
                strobe_d    = 4'b0010;
                issue_alu_d = 1'b1;
            end
            OP_DEC: begin
                strobe_d    = 4'b0001;
                issue_alu_d = 1'b1;
            end
            OP_LDI: begin
                direct_data_d = req_imm;
            end
            OP_MOV: begin
                direct_data_d = regs_q[req_rs];
            end
            default: begin
                direct_data_d = regs_q[req_rd];
            end
        endcase
    end

    // Sequencer state, register file, flags and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= RST_VAL;
            end
            op_q        <= 3'd0;
            rd_q        <= '0;
            rs_q        <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            flags_q     <= 5'b00000;
            strobe_q    <= 4'b0000;
        end else begin
            rsp_valid_q <= 1'b0;
            strobe_q    <= 4'b0000;
            case (state_q)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        op_q    <= req_op;
                        rd_q    <= req_rd;
                        rs_q    <= req_rs;
                        ready_q <= 1'b0;
                        if (issue_alu_d) begin
                            strobe_q <= strobe_d;
                            state_q  <= ISSUE;
                        end else begin
                            // NOP writes nothing; LDI and MOV commit right at the accept edge.
                            if ((req_op == OP_LDI) || (req_op == OP_MOV)) begin
                                regs_q[req_rd] <= direct_data_d;
                            end
                            rsp_data_q  <= direct_data_d;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    flags_q    <= {alu_cf, alu_af, alu_zf, alu_sf, alu_of};
                    rsp_data_q <= alu_res;
                    if (op_q != OP_CMP) begin
                        regs_q[rd_q] <= alu_res;
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign {flag_cf, flag_af, flag_zf, flag_sf, flag_of} = flags_q;
    assign {alu_add, alu_sub, alu_inc, alu_dec}          = strobe_q;
    assign alu_x     = regs_q[rd_q];
    assign alu_y     = regs_q[rs_q];
    assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a registered ALU model drives the DUT and
// a register-file/flag reference model predicts every response.
module tb_alu_issue_ctrl;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_INC = 3'd3;
    localparam logic [2:0] OP_DEC = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_MOV = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [1:0] req_rd;
    logic [1:0] req_rs;
    logic [7:0] req_imm;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       flag_cf, flag_af, flag_zf, flag_sf, flag_of;
    logic       alu_add, alu_sub, alu_inc, alu_dec;
    logic [7:0] alu_x, alu_y;
    logic [7:0] alu_res;
    logic       alu_cf, alu_af, alu_zf, alu_sf, alu_of;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    logic [12:0] alu_out_q;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_regs [4];
    logic [4:0] m_flags;            // {cf, af, zf, sf, of}
    logic [7:0] o_rsp;
    logic [4:0] o_flags;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.REG_AW(2), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs(req_rs), .req_imm(req_imm),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .flag_cf(flag_cf), .flag_af(flag_af), .flag_zf(flag_zf), .flag_sf(flag_sf), .flag_of(flag_of),
        .alu_add(alu_add), .alu_sub(alu_sub), .alu_inc(alu_inc), .alu_dec(alu_dec),
        .alu_x(alu_x), .alu_y(alu_y), .alu_res(alu_res),
        .alu_cf(alu_cf), .alu_af(alu_af), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Arithmetic on plain integers: carry into bit 7, nibble carry, signed overflow.
    function automatic logic [12:0] alu_fn(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        int         sx, sb, s, lo, nib;
        logic       sub;
        logic [7:0] b;
        logic [7:0] r;
        b   = ((op == OP_INC) || (op == OP_DEC)) ? 8'd1 : y;
        sub = (op == OP_SUB) || (op == OP_DEC) || (op == OP_CMP);
        sx  = $signed(x);
        sb  = $signed(b);
        s   = sub ? (sx - sb) : (sx + sb);
        lo  = sub ? (int'(x[6:0]) - int'(b[6:0])) : (int'(x[6:0]) + int'(b[6:0]));
        nib = sub ? (int'(x[3:0]) - int'(b[3:0])) : (int'(x[3:0]) + int'(b[3:0]));
        r   = s[7:0];
        return {r, (lo < 0) || (lo > 127), (nib < 0) || (nib > 15), r == 8'd0, r[7], (s < -128) || (s > 127)};
    endfunction

    // Registered ALU: a strobe at an edge produces result and flags for the following cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       alu_out_q <= 13'd0;
        else if (alu_add) alu_out_q <= alu_fn(OP_ADD, alu_x, alu_y);
        else if (alu_sub) alu_out_q <= alu_fn(OP_SUB, alu_x, alu_y);
        else if (alu_inc) alu_out_q <= alu_fn(OP_INC, alu_x, alu_y);
        else if (alu_dec) alu_out_q <= alu_fn(OP_DEC, alu_x, alu_y);
        else              alu_out_q <= alu_out_q;
    end
    assign {alu_res, alu_cf, alu_af, alu_zf, alu_sf, alu_of} = alu_out_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC) || (op == OP_CMP);
    endfunction

    // Architectural effect of one operation on the reference register file and flags.
    task automatic model_apply(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                               input logic [7:0] imm, output logic [7:0] rsp);
        logic [12:0] r;
        if (is_alu(op)) begin
            r       = alu_fn(op, m_regs[rd], m_regs[rs]);
            rsp     = r[12:5];
            m_flags = r[4:0];
            if (op != OP_CMP) m_regs[rd] = rsp;
        end else if (op == OP_LDI) begin
            rsp        = imm;
            m_regs[rd] = imm;
        end else if (op == OP_MOV) begin
            rsp        = m_regs[rs];
            m_regs[rd] = m_regs[rs];
        end else begin
            rsp = m_regs[rd];
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk($sformatf("%s R%0d", tag, i), 32'(dbg_data), 32'(m_regs[i]));
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm, input string tag,
                         output logic [7:0] rsp_o, output logic [4:0] flags_o);
        logic [7:0] exp_rsp, exp_x, exp_y;
        logic [3:0] exp_strobe;
        int         lat, w;
        @(negedge clk);
        w = 0;
        while (!req_ready && (w < 10)) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        case (op)
            OP_ADD:         exp_strobe = 4'b1000;
            OP_SUB, OP_CMP: exp_strobe = 4'b0100;
            OP_INC:         exp_strobe = 4'b0010;
            OP_DEC:         exp_strobe = 4'b0001;
            default:        exp_strobe = 4'b0000;
        endcase
        exp_x     = m_regs[rd];
        exp_y     = m_regs[rs];
        req_valid = 1'b1;
        req_op    = op;
        req_rd    = rd;
        req_rs    = rs;
        req_imm   = imm;
        model_apply(op, rd, rs, imm, exp_rsp);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_rd    = 2'($urandom);
        req_rs    = 2'($urandom);
        lat = 1;
        while (!rsp_valid && (lat < 6)) begin
            if (lat == 1) begin
                chk({tag, " strobe"}, 32'({alu_add, alu_sub, alu_inc, alu_dec}), 32'(exp_strobe));
                chk({tag, " alu_x"}, 32'(alu_x), 32'(exp_x));
                chk({tag, " alu_y"}, 32'(alu_y), 32'(exp_y));
            end else begin
                chk({tag, " strobe idle"}, 32'({alu_add, alu_sub, alu_inc, alu_dec}), 32'd0);
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " latency"}, 32'(lat), is_alu(op) ? 32'd3 : 32'd1);
        chk({tag, " rsp strobes off"}, 32'({alu_add, alu_sub, alu_inc, alu_dec}), 32'd0);
        chk({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_rsp));
        chk({tag, " flags"}, 32'({flag_cf, flag_af, flag_zf, flag_sf, flag_of}), 32'(m_flags));
        rsp_o   = rsp_data;
        flags_o = {flag_cf, flag_af, flag_zf, flag_sf, flag_of};
        check_regs(tag);
        @(negedge clk);
        chk({tag, " pulse end"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp hold"}, 32'(rsp_data), 32'(exp_rsp));
    endtask

    initial begin : main
        logic [7:0] exp_q [$];
        logic [2:0] b_op  [4];
        logic [1:0] b_rd  [4];
        logic [1:0] b_rs  [4];
        logic [7:0] b_imm [4];
        logic [7:0] e;
        int         idx, acc, nrsp;
        bit         will;

        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_rd = 2'd0; req_rs = 2'd0;
        req_imm = 8'h00; dbg_addr = 2'd0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_flags = 5'b00000;
        #23;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_data", 32'(rsp_data), 32'd0);
        chk("reset strobes", 32'({alu_add, alu_sub, alu_inc, alu_dec}), 32'd0);
        chk("reset flags", 32'({flag_cf, flag_af, flag_zf, flag_sf, flag_of}), 32'd0);
        chk("reset alu_xy", 32'({alu_x, alu_y}), 32'd0);
        check_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", 32'(req_ready), 32'd1);

        do_op(OP_LDI, 2'd0, 2'd0, 8'h7F, "ldi r0", o_rsp, o_flags);
        do_op(OP_LDI, 2'd1, 2'd0, 8'h01, "ldi r1", o_rsp, o_flags);
        do_op(OP_ADD, 2'd0, 2'd1, 8'h00, "add r0 r1", o_rsp, o_flags);
        chk("add result", 32'(o_rsp), 32'h80);
        chk("add flags cf af zf sf of", 32'(o_flags), 32'b11011);

        do_op(OP_LDI, 2'd2, 2'd0, 8'h05, "ldi r2", o_rsp, o_flags);
        do_op(OP_CMP, 2'd2, 2'd2, 8'h00, "cmp r2 r2", o_rsp, o_flags);
        chk("cmp result", 32'(o_rsp), 32'h00);
        chk("cmp zf", 32'(o_flags[2]), 32'd1);
        dbg_addr = 2'd2;
        #1;
        chk("cmp r2 unchanged", 32'(dbg_data), 32'h05);

        do_op(OP_LDI, 2'd3, 2'd0, 8'h80, "ldi r3", o_rsp, o_flags);
        do_op(OP_DEC, 2'd3, 2'd0, 8'h00, "dec r3", o_rsp, o_flags);
        chk("dec result", 32'(o_rsp), 32'h7F);
        chk("dec of sf", 32'(o_flags[1:0]), 32'b01);
        do_op(OP_INC, 2'd3, 2'd0, 8'h00, "inc r3", o_rsp, o_flags);
        chk("inc result", 32'(o_rsp), 32'h80);
        chk("inc of sf", 32'(o_flags[1:0]), 32'b11);
        do_op(OP_MOV, 2'd1, 2'd0, 8'h00, "mov r1 r0", o_rsp, o_flags);
        chk("mov result", 32'(o_rsp), 32'h80);
        chk("mov keeps flags", 32'(o_flags), 32'b11011);
        do_op(OP_NOP, 2'd3, 2'd1, 8'hAA, "nop r3", o_rsp, o_flags);
        do_op(OP_ADD, 2'd1, 2'd1, 8'h00, "add r1 r1", o_rsp, o_flags);

        // Reset while the ADD is in its ISSUE cycle: everything abandoned.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_ADD; req_rd = 2'd0; req_rs = 2'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid-issue add strobe", 32'(alu_add), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_flags = 5'b00000;
        chk("rst strobes drop", 32'({alu_add, alu_sub, alu_inc, alu_dec}), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst flags", 32'({flag_cf, flag_af, flag_zf, flag_sf, flag_of}), 32'd0);
        check_regs("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post reset no rsp", 32'(rsp_valid), 32'd0);
            chk("post reset ready", 32'(req_ready), 32'd1);
        end
        check_regs("post reset");

        for (int n = 0; n < 40; n++) begin
            do_op(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 8'($urandom),
                  $sformatf("rand%0d", n), o_rsp, o_flags);
        end

        // Back-to-back: req_valid held high across four operations.
        b_op  = '{OP_LDI, OP_ADD, OP_MOV, OP_SUB};
        b_rd  = '{2'd0, 2'd0, 2'd2, 2'd2};
        b_rs  = '{2'd0, 2'd0, 2'd0, 2'd1};
        b_imm = '{8'h33, 8'h00, 8'h00, 8'h00};
        idx = 0; acc = 0; nrsp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = b_op[0]; req_rd = b_rd[0]; req_rs = b_rs[0]; req_imm = b_imm[0];
        for (int cyc = 0; (cyc < 60) && (nrsp < 4); cyc++) begin
            will = req_valid && req_ready;
            if (rsp_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("b2b rsp%0d", nrsp), 32'(rsp_data), 32'(e));
                end else begin
                    chk("b2b spurious rsp", 32'(rsp_valid), 32'd0);
                end
                nrsp++;
            end
            if (will) begin
                model_apply(b_op[idx], b_rd[idx], b_rs[idx], b_imm[idx], e);
                exp_q.push_back(e);
                acc++;
                idx++;
            end
            @(posedge clk);
            @(negedge clk);
            if (will) begin
                if (idx < 4) begin
                    req_op = b_op[idx]; req_rd = b_rd[idx]; req_rs = b_rs[idx]; req_imm = b_imm[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        chk("b2b accepts", 32'(acc), 32'd4);
        chk("b2b responses", 32'(nrsp), 32'd4);
        chk("b2b flags", 32'({flag_cf, flag_af, flag_zf, flag_sf, flag_of}), 32'(m_flags));
        check_regs("b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
